// File: rtl/camera_load.sv
// rtl/camera_load.sv - SDRAM frame read-back with credit-limited requests and FWFT output FIFO
// Optional macro LOAD_CONTINUOUS_EN: refetch frames back-to-back instead of returning to IDLE.
module camera_load #(
    parameter logic [24:0] BASE_ADDR = 25'h0,
    parameter logic [24:0] LAST_ADDR = 25'hE1000,
    parameter int          DEPTH     = 8
) (
    input  logic         clk_133M,
    input  logic         rst_133M,
    input  logic         start,
    input  logic         ram_busy,
    output logic         rd_req,
    output logic [24:0]  rd_address,
    input  logic [255:0] rd_data,
    input  logic         rd_data_valid,
    output logic [255:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         frame_done,
    output logic         err_unexp
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [AW-1:0] P_ONE   = AW'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state;

    logic [255:0]  mem [DEPTH];
    logic [CW-1:0] outstanding, fifo_count;
    logic [CW-1:0] outstanding_n, count_n;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic          push, pop, credit;
    logic [255:0]  head_n;

    always_comb begin
        // A response with nothing outstanding is stray: it is flagged and never stored.
        push = rd_data_valid && (outstanding != '0);
        pop  = out_valid && out_ready;

        outstanding_n = outstanding;
        if (rd_req && !push)
            outstanding_n = outstanding + C_ONE;
        else if (!rd_req && push)
            outstanding_n = outstanding - C_ONE;

        count_n = fifo_count;
        if (push && !pop)
            count_n = fifo_count + C_ONE;
        else if (!push && pop)
            count_n = fifo_count - C_ONE;

        credit   = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C;
        rd_ptr_n = pop ? rd_ptr + P_ONE : rd_ptr;
        // wr_ptr meets rd_ptr_n on a push only when the FIFO is empty after the pop: bypass.
        head_n   = (push && (wr_ptr == rd_ptr_n)) ? rd_data : mem[rd_ptr_n];
    end

    always_ff @(posedge clk_133M) begin
        if (!rst_133M && push)
            mem[wr_ptr] <= rd_data;
    end

    always_ff @(posedge clk_133M) begin
        if (rst_133M) begin
            state       <= IDLE;
            rd_req      <= 1'b0;
            rd_address  <= BASE_ADDR;
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_unexp   <= 1'b0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_n;
            fifo_count  <= count_n;
            rd_ptr      <= rd_ptr_n;
            if (push)
                wr_ptr <= wr_ptr + P_ONE;

            out_valid <= (count_n != '0);
            if (count_n != '0)
                out_data <= head_n;

            if (rd_data_valid && (outstanding == '0))
                err_unexp <= 1'b1;

            rd_req     <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= FETCH;
                        busy       <= 1'b1;
                        rd_address <= BASE_ADDR;
                    end
                end
                FETCH: begin
                    if (rd_req) begin
                        if (rd_address == LAST_ADDR)
                            state <= DRAIN;
                        else
                            rd_address <= rd_address + 25'd8;
                    end else if (!ram_busy && credit) begin
                        rd_req <= 1'b1;
                    end
                end
                DRAIN: begin
                    if ((outstanding_n == '0) && (count_n == '0)) begin
                        frame_done <= 1'b1;
`ifdef LOAD_CONTINUOUS_EN
                        state      <= FETCH;
                        rd_address <= BASE_ADDR;
`else
                        state      <= IDLE;
                        busy       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_load.sv
// tb/tb_camera_load.sv - directed self-checking bench for camera_load (8-word frame, DEPTH 4)
module tb_camera_load;

    localparam logic [24:0] BASE = 25'h0;
    localparam logic [24:0] LAST = 25'h38;

    logic         clk_133M = 1'b0;
    logic         rst_133M = 1'b1;
    logic         start = 1'b0;
    logic         ram_busy = 1'b0;
    logic         rd_req;
    logic [24:0]  rd_address;
    logic [255:0] rd_data = '0;
    logic         rd_data_valid = 1'b0;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         frame_done;
    logic         err_unexp;

    camera_load #(.BASE_ADDR(BASE), .LAST_ADDR(LAST), .DEPTH(4)) dut (
        .clk_133M(clk_133M), .rst_133M(rst_133M), .start(start), .ram_busy(ram_busy),
        .rd_req(rd_req), .rd_address(rd_address), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .frame_done(frame_done), .err_unexp(err_unexp)
    );

    always #5 clk_133M = ~clk_133M;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_req, n_acc, n_done, first_req_cyc, last_hs_cyc, done_cyc, st_cyc;
    logic [24:0] exp_addr, exp_data_addr;
    int          due_q[$];
    logic [24:0] addr_q[$];

    function automatic logic [255:0] mkdata(input logic [24:0] a);
        return {4{32'hC0DE_0000 ^ {7'b0, a}, ~{7'b0, a}}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_req = 0; n_acc = 0; n_done = 0;
        first_req_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        exp_addr = BASE; exp_data_addr = BASE;
    endtask

    // Observe the current cycle, advance one clock, then play the RAM (3-cycle latency).
    task automatic tick();
        logic [24:0] a;
        if (rd_req) begin
            chk("req_addr", 256'(rd_address), 256'(exp_addr));
            exp_addr = (exp_addr == LAST) ? BASE : exp_addr + 25'd8;
            if (n_req == 0) first_req_cyc = cyc;
            n_req++;
            due_q.push_back(cyc + 3);
            addr_q.push_back(rd_address);
        end
        if (out_valid && out_ready) begin
            chk("out_word", out_data, mkdata(exp_data_addr));
            exp_data_addr = (exp_data_addr == LAST) ? BASE : exp_data_addr + 25'd8;
            n_acc++;
            last_hs_cyc = cyc;
        end
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        @(posedge clk_133M);
        #1;
        cyc++;
        rd_data_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            a = addr_q.pop_front();
            rd_data_valid = 1'b1;
            rd_data = mkdata(a);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        st_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        chk("done_in_budget", 256'(n_done), 256'(target));
    endtask

    task automatic do_reset();
        rst_133M = 1'b1;
        tick();
        tick();
        rst_133M = 1'b0;
    endtask

    initial begin
        clear_stats();
        do_reset();
        chk("rst_rd_req", 256'(rd_req), 256'(0));
        chk("rst_rd_address", 256'(rd_address), 256'(BASE));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", out_data, 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_frame_done", 256'(frame_done), 256'(0));
        chk("rst_err_unexp", 256'(err_unexp), 256'(0));

`ifdef LOAD_CONTINUOUS_EN
        out_ready = 1'b1;
        pulse_start();
        run_until_done(2, 600);
        chk("cont_words", 256'(n_acc), 256'(16));
        chk("cont_req_ge16", 256'(n_req >= 16), 256'(1));
        chk("cont_busy", 256'(busy), 256'(1));
        chk("cont_err", 256'(err_unexp), 256'(0));
`else
        // Full frame with a ready consumer.
        out_ready = 1'b1;
        pulse_start();
        run_until_done(1, 300);
        chk("t1_first_req_latency", 256'(first_req_cyc), 256'(st_cyc + 2));
        chk("t1_req_count", 256'(n_req), 256'(8));
        chk("t1_word_count", 256'(n_acc), 256'(8));
        chk("t1_done_after_last_hs", 256'(done_cyc), 256'(last_hs_cyc + 1));
        repeat (3) tick();
        chk("t1_busy_after", 256'(busy), 256'(0));
        chk("t1_single_done", 256'(n_done), 256'(1));
        chk("t1_no_extra_req", 256'(n_req), 256'(8));
        chk("t1_out_valid_after", 256'(out_valid), 256'(0));

        // Consumer stalled: credit caps requests at the FIFO depth.
        clear_stats();
        out_ready = 1'b0;
        pulse_start();
        repeat (40) tick();
        chk("t2_stall_req_count", 256'(n_req), 256'(4));
        chk("t2_hold_valid", 256'(out_valid), 256'(1));
        chk("t2_hold_word0", out_data, mkdata(25'h0));
        tick();
        chk("t2_hold_word0_again", out_data, mkdata(25'h0));
        out_ready = 1'b1;
        run_until_done(1, 300);
        chk("t2_req_count", 256'(n_req), 256'(8));
        chk("t2_word_count", 256'(n_acc), 256'(8));
        repeat (3) tick();

        // RAM busy right after start.
        clear_stats();
        ram_busy = 1'b1;
        pulse_start();
        repeat (10) tick();
        chk("t3_no_req_while_busy", 256'(n_req), 256'(0));
        ram_busy = 1'b0;
        st_cyc = cyc;
        run_until_done(1, 300);
        chk("t3_first_req_after_busy", 256'(first_req_cyc), 256'(st_cyc + 1));
        chk("t3_word_count", 256'(n_acc), 256'(8));
        repeat (3) tick();

        // Stray response while IDLE.
        clear_stats();
        chk("t4_err_before", 256'(err_unexp), 256'(0));
        rd_data = {8{32'hDEAD_BEEF}};
        rd_data_valid = 1'b1;
        tick();
        tick();
        chk("t4_err_set", 256'(err_unexp), 256'(1));
        chk("t4_fifo_empty", 256'(out_valid), 256'(0));
        repeat (5) tick();
        chk("t4_err_sticky", 256'(err_unexp), 256'(1));
        chk("t4_still_empty", 256'(out_valid), 256'(0));

        // Reset in the middle of a frame.
        do_reset();
        clear_stats();
        chk("t5_err_cleared", 256'(err_unexp), 256'(0));
        pulse_start();
        begin
            int k = 0;
            while (n_req < 3 && k < 50) begin
                tick();
                k++;
            end
        end
        chk("t5_three_reqs", 256'(n_req), 256'(3));
        rst_133M = 1'b1;
        tick();
        rst_133M = 1'b0;
        chk("t5_rd_req", 256'(rd_req), 256'(0));
        chk("t5_rd_address", 256'(rd_address), 256'(BASE));
        chk("t5_out_valid", 256'(out_valid), 256'(0));
        chk("t5_out_data", out_data, 256'(0));
        chk("t5_busy", 256'(busy), 256'(0));
        chk("t5_err_after_rst", 256'(err_unexp), 256'(0));
        repeat (3) tick();
        chk("t5_late_resp_err", 256'(err_unexp), 256'(1));
        chk("t5_late_resp_dropped", 256'(out_valid), 256'(0));
        repeat (5) tick();
        clear_stats();
        pulse_start();
        run_until_done(1, 300);
        chk("t5_refetch_words", 256'(n_acc), 256'(8));
        chk("t5_refetch_reqs", 256'(n_req), 256'(8));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
